// File: rtl/memwb_stage.sv
// Memory-to-writeback pipeline stage: registers the M-stage result for the
// register-file write port and waits on the data-memory response for loads.
module memwb_stage #(
    parameter int BITS    = 32,
    parameter int WAITMAX = 15
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            ValidM,
    input  logic            RegWriteM,
    input  logic            MemtoRegM,
    input  logic            PCSrcM,
    input  logic [3:0]      WA3M,
    input  logic [BITS-1:0] ALUOutM,
    input  logic [BITS-1:0] ReadDataM,
    input  logic            MemRdyM,
    output logic            RegWriteW,
    output logic            PCSrcW,
    output logic [3:0]      WA3W,
    output logic [BITS-1:0] ResultW,
    output logic            StallM,
    output logic            MemErrW
);

    localparam int CNT_W = $clog2(WAITMAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAITMAX - 1);

    localparam logic [0:0] S_IDLE      = 1'b0;
    localparam logic [0:0] S_WAIT_LOAD = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            reg_write_q, reg_write_d;
    logic            pc_src_q, pc_src_d;
    logic [3:0]      wa3_q, wa3_d;
    logic [BITS-1:0] result_q, result_d;
    logic            mem_err_q, mem_err_d;
    logic            stall;

    always_comb begin
        // NOTE: every signal gets a default here so no path infers a latch;
        // the defaults encode a bubble (write enables low, data held).
        state_d     = state_q;
        cnt_d       = cnt_q;
        reg_write_d = 1'b0;
        pc_src_d    = 1'b0;
        wa3_d       = wa3_q;
        result_d    = result_q;
        mem_err_d   = 1'b0;
        stall       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (ValidM) begin
                    if (!MemtoRegM || MemRdyM) begin
                        reg_write_d = RegWriteM;
                        pc_src_d    = PCSrcM;
                        wa3_d       = WA3M;
                        result_d    = MemtoRegM ? ReadDataM : ALUOutM;
                    end else begin
                        stall   = 1'b1;
                        cnt_d   = '0;
                        state_d = S_WAIT_LOAD;
                    end
                end
            end
            S_WAIT_LOAD: begin
                // A response on the last wait cycle still wins over the timeout.
                if (MemRdyM) begin
                    reg_write_d = RegWriteM;
                    pc_src_d    = PCSrcM;
                    wa3_d       = WA3M;
                    result_d    = MemtoRegM ? ReadDataM : ALUOutM;
                    state_d     = S_IDLE;
                end else if (cnt_q != CNT_LAST) begin
                    stall = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    mem_err_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: reset is synchronous and sampled only at the clock edge.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            reg_write_q <= 1'b0;
            pc_src_q    <= 1'b0;
            wa3_q       <= '0;
            result_q    <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            reg_write_q <= reg_write_d;
            pc_src_q    <= pc_src_d;
            wa3_q       <= wa3_d;
            result_q    <= result_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign StallM    = RESET & stall;
    assign RegWriteW = reg_write_q;
    assign PCSrcW    = pc_src_q;
    assign WA3W      = wa3_q;
    assign ResultW   = result_q;
    assign MemErrW   = mem_err_q;

endmodule

// File: tb/tb_memwb_stage.sv
// Self-checking bench for memwb_stage: directed scenarios followed by random
// traffic, all compared cycle by cycle against a transaction-level model.
module tb_memwb_stage;

    localparam int BITS    = 32;
    localparam int WAITMAX = 15;

    logic            CLK = 1'b0;
    logic            RESET;
    logic            ValidM, RegWriteM, MemtoRegM, PCSrcM, MemRdyM;
    logic [3:0]      WA3M;
    logic [BITS-1:0] ALUOutM, ReadDataM;
    logic            RegWriteW, PCSrcW, StallM, MemErrW;
    logic [3:0]      WA3W;
    logic [BITS-1:0] ResultW;

    memwb_stage #(.BITS(BITS), .WAITMAX(WAITMAX)) dut (
        .CLK(CLK), .RESET(RESET), .ValidM(ValidM), .RegWriteM(RegWriteM),
        .MemtoRegM(MemtoRegM), .PCSrcM(PCSrcM), .WA3M(WA3M), .ALUOutM(ALUOutM),
        .ReadDataM(ReadDataM), .MemRdyM(MemRdyM), .RegWriteW(RegWriteW),
        .PCSrcW(PCSrcW), .WA3W(WA3W), .ResultW(ResultW), .StallM(StallM),
        .MemErrW(MemErrW)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: a load is "pending" from the cycle it enters M; its age
    // counts cycles since entry. It may stall for WAITMAX cycles in total.
    bit              m_pend = 1'b0;
    int              m_age  = 0;
    bit              e_stall;
    logic            e_rw, e_pc, e_err;
    logic [3:0]      e_wa;
    logic [BITS-1:0] e_res;
    logic            n_rw, n_pc, n_err;
    logic [3:0]      n_wa;
    logic [BITS-1:0] n_res;
    bit              n_pend;
    int              n_age;

    task automatic model_eval();
        bit do_capture;
        do_capture = 1'b0;
        e_stall = 1'b0;
        n_rw = 1'b0; n_pc = 1'b0; n_err = 1'b0;
        n_wa = e_wa; n_res = e_res;
        n_pend = m_pend; n_age = m_age;
        if (!RESET) begin
            n_wa = '0; n_res = '0; n_pend = 1'b0; n_age = 0;
        end else if (!m_pend) begin
            if (ValidM && (!MemtoRegM || MemRdyM)) do_capture = 1'b1;
            else if (ValidM) begin
                e_stall = 1'b1; n_pend = 1'b1; n_age = 1;
            end
        end else begin
            if (MemRdyM) begin
                do_capture = 1'b1; n_pend = 1'b0;
            end else if (m_age < WAITMAX) begin
                e_stall = 1'b1; n_age = m_age + 1;
            end else begin
                n_err = 1'b1; n_pend = 1'b0;
            end
        end
        if (do_capture) begin
            n_rw = RegWriteM; n_pc = PCSrcM; n_wa = WA3M;
            n_res = MemtoRegM ? ReadDataM : ALUOutM;
        end
    endtask

    // One clock cycle with the currently driven inputs.
    task automatic run_cycle();
        model_eval();
        @(negedge CLK);
        check("StallM", 64'(StallM), 64'(e_stall));
        check("RegWriteW", 64'(RegWriteW), 64'(e_rw));
        check("PCSrcW", 64'(PCSrcW), 64'(e_pc));
        check("WA3W", 64'(WA3W), 64'(e_wa));
        check("ResultW", 64'(ResultW), 64'(e_res));
        check("MemErrW", 64'(MemErrW), 64'(e_err));
        @(posedge CLK);
        #1;
        e_rw = n_rw; e_pc = n_pc; e_wa = n_wa; e_res = n_res; e_err = n_err;
        m_pend = n_pend; m_age = n_age;
    endtask

    task automatic set_m(input logic v, input logic rw, input logic m2r, input logic pc,
                         input logic [3:0] wa, input logic [BITS-1:0] alu,
                         input logic [BITS-1:0] rd, input logic rdy);
        ValidM = v; RegWriteM = rw; MemtoRegM = m2r; PCSrcM = pc;
        WA3M = wa; ALUOutM = alu; ReadDataM = rd; MemRdyM = rdy;
    endtask

    task automatic bubble(input int n);
        set_m(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, '0, '0, 1'b0);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    task automatic load_wait(input logic [3:0] wa, input int lows, input logic [BITS-1:0] data);
        set_m(1'b1, 1'b1, 1'b1, 1'b0, wa, 32'hAAAA_0000, 32'h5555_5555, 1'b0);
        for (int i = 0; i < lows; i++) run_cycle();
        ReadDataM = data;
        MemRdyM   = 1'b1;
        run_cycle();
    endtask

    int err_pulses;
    int delay;

    initial begin
        RESET = 1'b0;
        set_m(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, '0, '0, 1'b0);
        @(posedge CLK);
        #1;
        e_rw = 1'b0; e_pc = 1'b0; e_err = 1'b0; e_wa = '0; e_res = '0;

        // Reset held two cycles, then one ALU write.
        run_cycle();
        run_cycle();
        RESET = 1'b1;
        set_m(1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 32'h0000_0005, 32'h0, 1'b0);
        run_cycle();
        bubble(2);

        // Load answered immediately.
        set_m(1'b1, 1'b1, 1'b1, 1'b0, 4'd7, 32'h0, 32'hDEAD_BEEF, 1'b1);
        run_cycle();
        bubble(1);

        // Load answered after three stall cycles.
        load_wait(4'd2, 3, 32'h0000_1234);
        bubble(2);

        // Timeout, then a normal ALU write.
        set_m(1'b1, 1'b1, 1'b1, 1'b0, 4'd4, 32'h0, 32'h0, 1'b0);
        err_pulses = 0;
        for (int i = 0; i <= WAITMAX; i++) run_cycle();
        set_m(1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 32'h0000_0077, 32'h0, 1'b0);
        if (MemErrW) err_pulses++;
        run_cycle();
        if (MemErrW) err_pulses++;
        bubble(1);
        check("timeout_err_pulses", 64'(err_pulses), 64'd1);

        // Response on the last permitted wait cycle wins over the timeout.
        load_wait(4'd6, WAITMAX, 32'hCAFE_F00D);
        bubble(2);

        // Reset during the wait discards the load.
        set_m(1'b1, 1'b1, 1'b1, 1'b0, 4'd8, 32'h0, 32'h0, 1'b0);
        run_cycle();
        run_cycle();
        RESET = 1'b0;
        run_cycle();
        RESET = 1'b1;
        bubble(3);

        // PC write, then two back-to-back loads answered after one cycle.
        set_m(1'b1, 1'b1, 1'b0, 1'b1, 4'd15, 32'h0000_0100, 32'h0, 1'b0);
        run_cycle();
        load_wait(4'd9, 1, 32'h1111_1111);
        load_wait(4'd10, 1, 32'h2222_2222);
        bubble(2);

        // Random traffic; M-stage fields are held while a load is pending.
        delay = 0;
        for (int c = 0; c < 3000; c++) begin
            RESET = ($urandom_range(0, 199) != 0);
            ReadDataM = $urandom();
            if (!m_pend) begin
                ValidM    = ($urandom_range(0, 3) != 0);
                RegWriteM = ($urandom_range(0, 4) != 0);
                MemtoRegM = ($urandom_range(0, 2) == 0);
                PCSrcM    = ($urandom_range(0, 7) == 0);
                WA3M      = 4'($urandom_range(0, 15));
                ALUOutM   = $urandom();
                delay     = $urandom_range(0, WAITMAX + 1);
                if ($urandom_range(0, 3) == 0) delay = 0;
                if (ValidM && MemtoRegM) MemRdyM = (delay == 0);
                else MemRdyM = ($urandom_range(0, 1) == 1);
            end else begin
                MemRdyM = (m_age == delay);
            end
            run_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
